// File: rtl/bus_pkg.sv
// Shared definitions for the registered datapath bus gate/arbiter.
// Contents:
//   bus_state_t       - arbiter state encoding (IDLE, DRIVE, FAULT)
//   SEL_BINARY/ONEHOT - values of the SEL_MODE parameter
//   src_slice()       - extracts source k from a flattened source vector
package bus_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      FAULT = 2'd2
   } bus_state_t;

   localparam int SEL_BINARY = 0;
   localparam int SEL_ONEHOT = 1;

   // Upper bounds for the generic slice helper; callers zero-extend into
   // this container and keep only the low WIDTH bits of the result.
   localparam int SRC_MAX_WIDTH = 64;
   localparam int SRC_MAX_NSRC  = 16;

   // Source k lives at bits [k*width +: width] of the flattened vector.
   function automatic logic [SRC_MAX_WIDTH-1:0] src_slice(
      input logic [SRC_MAX_NSRC*SRC_MAX_WIDTH-1:0] din,
      input int unsigned                           k,
      input int unsigned                           width
   );
      logic [SRC_MAX_NSRC*SRC_MAX_WIDTH-1:0] shifted;
      shifted = din >> (k * width);
      return shifted[SRC_MAX_WIDTH-1:0];
   endfunction

endpackage

// File: rtl/bus_gate_arbiter_onehot_decode.sv
// One-hot Gate decoder: counts the asserted Gate bits and reports the
// position of the set bit.
// Ports:
//   Gate  in  NSRC          drive enables
//   idx   out $clog2(NSRC)  position of a set bit (meaningful when any && !multi)
//   any   out 1             at least one Gate bit set
//   multi out 1             more than one Gate bit set (bus conflict)
module onehot_decode
   import bus_pkg::*;
#(
   parameter int NSRC = 4
) (
   input  logic [NSRC-1:0]         Gate,
   output logic [$clog2(NSRC)-1:0] idx,
   output logic                    any,
   output logic                    multi
);

   localparam int IW = $clog2(NSRC);
   localparam int CW = $clog2(NSRC + 1);

   logic [CW-1:0] cnt_s;
   logic [IW-1:0] idx_s;

   // Popcount of Gate plus the index of the highest set bit.
   always_comb begin
      cnt_s = '0;
      idx_s = '0;
      for (int i = 0; i < NSRC; i++) begin
         if (Gate[i]) begin
            cnt_s = cnt_s + CW'(1);
            idx_s = IW'(i);
         end else begin
            cnt_s = cnt_s;
         end
      end
   end

   assign idx   = idx_s;
   assign any   = (cnt_s != '0);
   assign multi = (cnt_s > CW'(1));

endmodule

// File: rtl/bus_gate_arbiter.sv
// Registered bus gate/arbiter: places one of NSRC sources onto the shared
// datapath bus one cycle after it is requested, and traps multi-drive
// conflicts in a FAULT state until software clears them.
// Ports:
//   Clk, Reset_n    clock (rising edge), async active-low reset
//   Din             flattened sources, source k at [k*WIDTH +: WIDTH]
//   Gate            one-hot drive enables (SEL_MODE=1)
//   sel, sel_valid  binary source select (SEL_MODE=0)
//   err_clr         leaves FAULT on the edge it is sampled high
//   Dout            registered bus value
//   Dout_valid      Dout was driven by a source on the previous cycle
//   src_id          source that produced Dout
//   conflict        single-cycle multi-drive indication
//   fault           high while in FAULT
module bus_gate_arbiter
   import bus_pkg::*;
#(
   parameter int WIDTH     = 16,
   parameter int NSRC      = 4,
   parameter int SEL_MODE  = 1,
   parameter int HOLD_LAST = 1
) (
   input  logic                    Clk,
   input  logic                    Reset_n,
   input  logic [NSRC*WIDTH-1:0]   Din,
   input  logic [NSRC-1:0]         Gate,
   input  logic [$clog2(NSRC)-1:0] sel,
   input  logic                    sel_valid,
   input  logic                    err_clr,
   output logic [WIDTH-1:0]        Dout,
   output logic                    Dout_valid,
   output logic [$clog2(NSRC)-1:0] src_id,
   output logic                    conflict,
   output logic                    fault
);

   localparam int IW = $clog2(NSRC);

   bus_state_t state_r, state_nxt_s;
   logic [WIDTH-1:0] dout_r, dout_nxt_s;
   logic             valid_r, valid_nxt_s;
   logic [IW-1:0]    src_r, src_nxt_s;
   logic             conflict_r, conflict_nxt_s;
   logic             fault_r;

   logic [IW-1:0]    oh_idx_s;
   logic             oh_any_s, oh_multi_s;
   logic             bin_req_s;
   logic             req_s, multi_s;
   logic [IW-1:0]    idx_s;

   logic [SRC_MAX_NSRC*SRC_MAX_WIDTH-1:0] din_ext_s;
   logic [SRC_MAX_WIDTH-1:0]              slice_s;
   logic                                  unused_s;

   generate
      if (SEL_MODE == SEL_ONEHOT) begin : g_onehot
         onehot_decode #(.NSRC(NSRC)) u_decode (
            .Gate  (Gate),
            .idx   (oh_idx_s),
            .any   (oh_any_s),
            .multi (oh_multi_s)
         );
      end else begin : g_binary
         assign oh_idx_s   = '0;
         assign oh_any_s   = 1'b0;
         assign oh_multi_s = 1'b0;
      end
   endgenerate

   // An out-of-range binary select is treated as no request at all.
   assign bin_req_s = sel_valid && ({1'b0, sel} < (IW+1)'(NSRC));

   // Request decode for the configured select style.
   always_comb begin
      if (SEL_MODE == SEL_ONEHOT) begin
         req_s   = oh_any_s && !oh_multi_s;
         multi_s = oh_multi_s;
         idx_s   = oh_idx_s;
      end else begin
         req_s   = bin_req_s;
         multi_s = 1'b0;
         idx_s   = sel;
      end
   end

   // Zero-extend the sources into the container used by src_slice().
   always_comb begin
      din_ext_s = '0;
      din_ext_s[NSRC*WIDTH-1:0] = Din;
   end

   assign slice_s  = src_slice(din_ext_s, 32'(idx_s), WIDTH);
   assign unused_s = ^{Gate, sel, sel_valid, slice_s};

   // Next-state and next-output logic; everything lands in registers.
   always_comb begin
      state_nxt_s    = state_r;
      dout_nxt_s     = dout_r;
      valid_nxt_s    = 1'b0;
      src_nxt_s      = src_r;
      conflict_nxt_s = 1'b0;
      case (state_r)
         IDLE, DRIVE: begin
            if (multi_s) begin
               state_nxt_s    = FAULT;
               dout_nxt_s     = '0;
               conflict_nxt_s = 1'b1;
            end else if (req_s) begin
               state_nxt_s = DRIVE;
               dout_nxt_s  = slice_s[WIDTH-1:0];
               valid_nxt_s = 1'b1;
               src_nxt_s   = idx_s;
            end else begin
               state_nxt_s = IDLE;
               dout_nxt_s  = (HOLD_LAST != 0) ? dout_r : '0;
            end
         end
         FAULT: begin
            dout_nxt_s = '0;
            // Clearing wins over any request or conflict in the same cycle.
            if (err_clr) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s    = FAULT;
               conflict_nxt_s = multi_s;
            end
         end
         default: begin
            state_nxt_s = IDLE;
            dout_nxt_s  = '0;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_r    <= IDLE;
         dout_r     <= '0;
         valid_r    <= 1'b0;
         src_r      <= '0;
         conflict_r <= 1'b0;
         fault_r    <= 1'b0;
      end else begin
         state_r    <= state_nxt_s;
         dout_r     <= dout_nxt_s;
         valid_r    <= valid_nxt_s;
         src_r      <= src_nxt_s;
         conflict_r <= conflict_nxt_s;
         fault_r    <= (state_nxt_s == FAULT);
      end
   end

   assign Dout       = dout_r;
   assign Dout_valid = valid_r;
   assign src_id     = src_r;
   assign conflict   = conflict_r;
   assign fault      = fault_r;

endmodule
